// File: rtl/base2_lif_neuron.sv
// Postsynaptic leaky integrate-and-fire neuron with base-2 (shift) leak; feeds post_spike back to the STDP synapse.
// Latency: membrane and post_spike are registered, so a crossing pre_spike shows up as post_spike on the next cycle.
// Backpressure: none; pre_spike events that arrive during the refractory window are dropped, not queued.
//
// Ports:
//   clk         rising-edge system clock
//   rst         synchronous active-high reset (priority over everything)
//   pre_spike   one-cycle presynaptic spike; weight is sampled in the same cycle
//   weight      unsigned synaptic weight from the STDP block
//   post_spike  registered one-cycle firing pulse
//   membrane    current membrane potential
//   refractory  high while the neuron is in its refractory window
//   spike_count 16-bit wrapping count of emitted spikes (only with SPIKE_COUNT_EN)
//
// Optional feature macro: SPIKE_COUNT_EN adds the spike_count port and register.

module base2_lif_neuron #(
    parameter int                 W_WIDTH        = 16,
    parameter int                 V_WIDTH        = 20,
    parameter logic [V_WIDTH-1:0] THRESHOLD      = 20'd4096,
    parameter int                 LEAK_SHIFT     = 4,
    parameter int                 LEAK_PERIOD    = 8,
    parameter int                 REFRACT_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pre_spike,
    input  logic [W_WIDTH-1:0] weight,
    output logic               post_spike,
    output logic [V_WIDTH-1:0] membrane,
    output logic               refractory
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]        spike_count
`endif
);

    // Counter widths; a period of 1 still needs a 1-bit counter that stays at 0.
    localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RCW = $clog2(REFRACT_CYCLES + 1);

    localparam logic [LCW-1:0] LEAK_LAST = LCW'(LEAK_PERIOD - 1);
    localparam logic [RCW-1:0] REFR_LOAD = RCW'(REFRACT_CYCLES);
    localparam logic [RCW-1:0] REFR_ONE  = RCW'(1);

    // FSM encoding
    localparam logic [0:0] ST_INTEGRATE = 1'b0;
    localparam logic [0:0] ST_REFRACT   = 1'b1;

    logic [0:0]         state_q,    state_d;
    logic [V_WIDTH-1:0] v_q,        v_d;
    logic [LCW-1:0]     leak_cnt_q, leak_cnt_d;
    logic [RCW-1:0]     refr_cnt_q, refr_cnt_d;
    logic               post_q,     post_d;

    // Integration datapath
    logic               leak_evt;
    logic [V_WIDTH-1:0] v_leak;
    logic [V_WIDTH:0]   v_sum;
    logic [V_WIDTH-1:0] v_int;
    logic               fire;

    assign leak_evt = (leak_cnt_q == LEAK_LAST);

    // Leak is applied before the incoming weight is added.
    assign v_leak = leak_evt ? (v_q - (v_q >> LEAK_SHIFT)) : v_q;

    // One extra bit catches the carry so the sum can saturate instead of wrapping.
    assign v_sum = {1'b0, v_leak} + {{(V_WIDTH + 1 - W_WIDTH){1'b0}}, weight};

    always_comb begin
        v_int = v_leak;
        if (pre_spike) begin
            v_int = v_sum[V_WIDTH] ? {V_WIDTH{1'b1}} : v_sum[V_WIDTH-1:0];
        end
    end

    // Without a pre_spike the leak only shrinks v, and v was already below
    // threshold, so a leak alone can never fire.
    assign fire = (v_int >= THRESHOLD);

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        leak_cnt_d = leak_cnt_q;
        refr_cnt_d = refr_cnt_q;
        post_d     = 1'b0;

        case (state_q)
            ST_INTEGRATE: begin
                if (fire) begin
                    v_d        = '0;
                    post_d     = 1'b1;
                    refr_cnt_d = REFR_LOAD;
                    leak_cnt_d = '0;
                    state_d    = ST_REFRACT;
                end else begin
                    v_d        = v_int;
                    leak_cnt_d = leak_evt ? '0 : leak_cnt_q + 1'b1;
                end
            end

            default: begin
                // Inputs are ignored here; the leak phase restarts from 0 on exit.
                v_d        = '0;
                leak_cnt_d = '0;
                if (refr_cnt_q == REFR_ONE) begin
                    refr_cnt_d = '0;
                    state_d    = ST_INTEGRATE;
                end else begin
                    refr_cnt_d = refr_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INTEGRATE;
            v_q        <= '0;
            leak_cnt_q <= '0;
            refr_cnt_q <= '0;
            post_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            leak_cnt_q <= leak_cnt_d;
            refr_cnt_q <= refr_cnt_d;
            post_q     <= post_d;
        end
    end

    assign post_spike = post_q;
    assign membrane   = v_q;
    assign refractory = (state_q == ST_REFRACT);

`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_cnt_q, spike_cnt_d;

    // Counts cycles in which post_spike is high; wraps naturally at 16 bits.
    assign spike_cnt_d = post_q ? spike_cnt_q + 16'd1 : spike_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_cnt_q <= '0;
        end else begin
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign spike_count = spike_cnt_q;
`endif

endmodule

// File: tb/tb_base2_lif_neuron.sv
module tb_base2_lif_neuron;

    logic        clk;
    logic        rst;
    logic        pre_spike;
    logic [15:0] weight;
    logic        post_spike;
    logic [19:0] membrane;
    logic        refractory;

    logic        pre_s;
    logic [15:0] w_s;
    logic        post_s;
    logic [19:0] membrane_s;
    logic        refr_s;

`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_count;
    logic [15:0] spike_count_s;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    base2_lif_neuron dut (
        .clk        (clk),
        .rst        (rst),
        .pre_spike  (pre_spike),
        .weight     (weight),
        .post_spike (post_spike),
        .membrane   (membrane),
        .refractory (refractory)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count(spike_count)
`endif
    );

    // Max threshold and a long leak period so 17 spikes see no leak event.
    base2_lif_neuron #(
        .THRESHOLD   (20'hFFFFF),
        .LEAK_PERIOD (100)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .pre_spike  (pre_s),
        .weight     (w_s),
        .post_spike (post_s),
        .membrane   (membrane_s),
        .refractory (refr_s)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count(spike_count_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pre_spike = 1'b0;
        pre_s     = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        pre_spike = 1'b1;
        weight    = 16'hFFFF;
        pre_s     = 1'b1;
        w_s       = 16'hFFFF;
        step();
        step();
        tests_run++;
        if (membrane !== 20'd0 || post_spike !== 1'b0 || refractory !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: membrane=%0d post=%b refr=%b required 0/0/0", membrane, post_spike, refractory);
        end
        tests_run++;
        if (membrane_s !== 20'd0 || post_s !== 1'b0 || refr_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state_sat: membrane=%0d post=%b refr=%b required 0/0/0", membrane_s, post_s, refr_s);
        end
`ifdef SPIKE_COUNT_EN
        tests_run++;
        if (spike_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_spike_count: got %0d required 0", spike_count);
        end
`endif
        pre_spike = 1'b0;
        pre_s     = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_integrate_fire();
        int posts;
        int refrs;
        do_reset();
        weight    = 16'h0800;
        pre_spike = 1'b1;
        step();
        tests_run++;
        if (membrane !== 20'd2048 || post_spike !== 1'b0) begin
            tests_failed++;
            $display("FAIL fire_first_spike: membrane=%0d post=%b required 2048/0", membrane, post_spike);
        end
        step();
        pre_spike = 1'b0;
        tests_run++;
        if (post_spike !== 1'b1 || membrane !== 20'd0 || refractory !== 1'b1) begin
            tests_failed++;
            $display("FAIL fire_pulse: post=%b membrane=%0d refr=%b required 1/0/1", post_spike, membrane, refractory);
        end
        posts = 1;
        refrs = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (post_spike === 1'b1) posts++;
            if (refractory === 1'b1) refrs++;
        end
        tests_run++;
        if (posts != 1) begin
            tests_failed++;
            $display("FAIL fire_pulse_width: post_spike high %0d cycles required 1", posts);
        end
        tests_run++;
        if (refrs != 5) begin
            tests_failed++;
            $display("FAIL refractory_length: refractory high %0d cycles required 5", refrs);
        end
`ifdef SPIKE_COUNT_EN
        tests_run++;
        if (spike_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL spike_count_incr: got %0d required 1", spike_count);
        end
`endif
    endtask

    task automatic test_leak();
        int posts;
        do_reset();
        weight    = 16'h0400;
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        tests_run++;
        if (membrane !== 20'd1024) begin
            tests_failed++;
            $display("FAIL leak_initial: membrane=%0d required 1024", membrane);
        end
        posts = 0;
        // weight wiggles with pre_spike low and must have no effect
        for (int i = 0; i < 6; i++) begin
            weight = 16'(16'h1234 * (i + 1));
            step();
            if (post_spike === 1'b1) posts++;
        end
        tests_run++;
        if (membrane !== 20'd1024) begin
            tests_failed++;
            $display("FAIL leak_before_event: membrane=%0d required 1024", membrane);
        end
        step();
        tests_run++;
        if (membrane !== 20'd960) begin
            tests_failed++;
            $display("FAIL leak_first_event: membrane=%0d required 960", membrane);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (post_spike === 1'b1) posts++;
        end
        tests_run++;
        if (membrane !== 20'd900 || posts != 0) begin
            tests_failed++;
            $display("FAIL leak_second_event: membrane=%0d posts=%0d required 900/0", membrane, posts);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        weight    = 16'h0400;
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        for (int i = 0; i < 7; i++) step();
        tests_run++;
        if (membrane !== 20'd960) begin
            tests_failed++;
            $display("FAIL simul_setup: membrane=%0d required 960", membrane);
        end
        for (int i = 0; i < 7; i++) step();
        weight    = 16'h0040;
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        tests_run++;
        if (membrane !== 20'd964) begin
            tests_failed++;
            $display("FAIL simul_leak_add: membrane=%0d required 964", membrane);
        end
    endtask

    task automatic test_refract_drop();
        int bad;
        do_reset();
        weight    = 16'h0800;
        pre_spike = 1'b1;
        step();
        step();
        weight = 16'h0FFF;
        bad    = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (membrane !== 20'd0 || post_spike !== 1'b0) bad++;
        end
        pre_spike = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL refract_drop: %0d cycles with membrane!=0 or post_spike, required 0", bad);
        end
        step();
        tests_run++;
        if (refractory !== 1'b1) begin
            tests_failed++;
            $display("FAIL refract_last_cycle: refr=%b required 1", refractory);
        end
        step();
        tests_run++;
        if (refractory !== 1'b0 || membrane !== 20'd0) begin
            tests_failed++;
            $display("FAIL refract_exit: refr=%b membrane=%0d required 0/0", refractory, membrane);
        end
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        tests_run++;
        if (membrane !== 20'd4095 || post_spike !== 1'b0) begin
            tests_failed++;
            $display("FAIL refract_followup: membrane=%0d post=%b required 4095/0", membrane, post_spike);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        w_s   = 16'hFFFF;
        pre_s = 1'b1;
        for (int i = 0; i < 16; i++) step();
        tests_run++;
        if (membrane_s !== 20'd1048560 || post_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_16: membrane=%0d post=%b required 1048560/0", membrane_s, post_s);
        end
        step();
        pre_s = 1'b0;
        tests_run++;
        if (post_s !== 1'b1 || membrane_s !== 20'd0 || refr_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_17_fire: post=%b membrane=%0d refr=%b required 1/0/1", post_s, membrane_s, refr_s);
        end
    endtask

    task automatic test_reset_mid_refract();
        do_reset();
        weight    = 16'h0800;
        pre_spike = 1'b1;
        step();
        step();
        pre_spike = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (refractory !== 1'b0 || membrane !== 20'd0 || post_spike !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_refract: refr=%b membrane=%0d post=%b required 0/0/0", refractory, membrane, post_spike);
        end
`ifdef SPIKE_COUNT_EN
        tests_run++;
        if (spike_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_refract_count: got %0d required 0", spike_count);
        end
`endif
        weight    = 16'h0100;
        pre_spike = 1'b1;
        step();
        pre_spike = 1'b0;
        tests_run++;
        if (membrane !== 20'd256) begin
            tests_failed++;
            $display("FAIL rst_mid_refract_integrate: membrane=%0d required 256", membrane);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pre_spike = 1'b1;
        weight    = 16'h0100;
        step();
        weight = 16'h0200;
        step();
        weight = 16'h0300;
        step();
        pre_spike = 1'b0;
        tests_run++;
        if (membrane !== 20'd1536 || post_spike !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back: membrane=%0d post=%b required 1536/0", membrane, post_spike);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pre_spike = 1'b0;
        weight    = 16'h0000;
        pre_s     = 1'b0;
        w_s       = 16'h0000;
        test_reset();
        test_integrate_fire();
        test_leak();
        test_simultaneous();
        test_refract_drop();
        test_saturation();
        test_reset_mid_refract();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/base2_lif_neuron.md
Name: base2_lif_neuron

Overview:
- Postsynaptic leaky integrate-and-fire neuron; the consumer end of the base-2 STDP synapse.
- Takes the synapse's `weight` output plus `pre_spike`, integrates the weight into a membrane potential, and applies a base-2 (shift) leak.
- Emits the `post_spike` pulse that feeds back into the STDP block's `post_spike` input, closing the learning loop.
- All arithmetic is unsigned, shift-based, no multipliers.

Parameters:
- W_WIDTH, 16: width of the `weight` input (matches the STDP weight bus).
- V_WIDTH, 20: width of the membrane accumulator; must be > W_WIDTH.
- THRESHOLD, 20'd4096: firing threshold; fire when the membrane value is >= THRESHOLD.
- LEAK_SHIFT, 4: leak amount per leak event is v >> LEAK_SHIFT.
- LEAK_PERIOD, 8: clock cycles between leak events; must be >= 1.
- REFRACT_CYCLES, 5: refractory length in cycles; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- pre_spike  input  1  one-cycle presynaptic spike; `weight` is sampled in the same cycle.
- weight  input  W_WIDTH  unsigned synaptic weight from the STDP block.
- post_spike  output  1  registered one-cycle firing pulse.
- membrane  output  V_WIDTH  current membrane potential (register).
- refractory  output  1  high while in the REFRACT state.
- spike_count  output  16  present only with SPIKE_COUNT_EN.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other logic. With `rst` high at an edge:
  - state <= INTEGRATE
  - membrane, leak counter, refractory counter and spike_count <= 0
  - post_spike <= 0
  - Applies mid-refractory and mid-integration alike.
- Leak counter:
  - Runs 0..LEAK_PERIOD-1 in INTEGRATE only.
  - Held at 0 in REFRACT and on the exit cycle from REFRACT.
  - A leak event occurs in a cycle where the counter equals LEAK_PERIOD-1; the counter then wraps to 0.
- INTEGRATE, next-value computation:
  - v1 = leak event ? v - (v >> LEAK_SHIFT) : v
  - v2 = pre_spike ? v1 + zero-extended weight : v1
  - The sum saturates at 2^V_WIDTH-1; no wrap-around.
  - A simultaneous leak and pre_spike is therefore leak-first, then add.
- INTEGRATE, no firing (v2 < THRESHOLD): membrane <= v2, post_spike <= 0.
- INTEGRATE, firing (v2 >= THRESHOLD):
  - membrane <= 0
  - post_spike <= 1 for exactly one cycle
  - refractory counter <= REFRACT_CYCLES
  - state <= REFRACT
  - Latency: post_spike is high in the cycle after the edge that sampled the crossing pre_spike.
- Threshold checks only occur through integration; a leak alone never triggers a fire.
- REFRACT:
  - membrane held at 0; pre_spike and weight ignored (dropped, not queued).
  - refractory = 1; post_spike = 0 after its single pulse.
  - Refractory counter decrements each cycle. When it equals 1, the next edge returns to INTEGRATE.
  - refractory is high for exactly REFRACT_CYCLES cycles.
  - A pre_spike in the cycle refractory is low again is integrated normally.
- weight changing while pre_spike is low has no effect.
- Back-to-back pre_spikes on consecutive cycles are each integrated.

Optional Feature:
- Macro: SPIKE_COUNT_EN.
- Defined:
  - `spike_count` port exists: a 16-bit register incremented on each cycle post_spike is asserted.
  - Wraps 0xFFFF -> 0x0000; cleared by rst.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Integrate and fire (defaults):
  - Stimulus: rst high 2 cycles, then weight=0x0800 with pre_spike on 2 consecutive cycles.
  - Response: membrane 2048, then fire; post_spike high exactly 1 cycle, the cycle after the second spike; membrane=0; refractory high exactly 5 cycles.
- Leak:
  - Stimulus: one pre_spike with weight=0x0400 at cycle 0 after reset, then idle.
  - Response: membrane 1024 -> 960 at the first leak event (counter=7) -> 900 eight cycles later; no post_spike.
- Refractory drop:
  - Stimulus: fire, then 3 pre_spikes of weight=0x0FFF during refractory.
  - Response: membrane stays 0, no second post_spike.
  - Follow-up: one pre_spike of 0x0FFF right after refractory falls gives membrane=4095 with no fire.
- Saturation:
  - Stimulus: THRESHOLD=20'hFFFFF, weight=0xFFFF, 17 consecutive pre_spikes.
  - Response: membrane 1048560 after 16; the 17th saturates to 1048575 and fires.
- Simultaneous leak and spike:
  - Stimulus: membrane=960, pre_spike with weight=0x0040 in the leak cycle.
  - Response: membrane=960-60+64=964.
- Reset mid-refractory:
  - Stimulus: rst asserted 1 cycle, 2 cycles into REFRACT.
  - Response: refractory=0, membrane=0, spike_count=0 (SPIKE_COUNT_EN); the next pre_spike is integrated.
